// File: rtl/db_ram_1p_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : db_ram_1p_ctrl_pkg
// Brief    : Shared encodings and default widths for the deblocking
//            single-port RAM controller slice.
// Revision : 1.0 - initial release
// ============================================================================
package db_ram_1p_ctrl_pkg;

    // Default geometry of the deblocking line/pixel RAMs
    localparam int DB_WORD_WIDTH = 128;
    localparam int DB_ADDR_WIDTH = 8;

    // Active-low RAM control pin encodings
    localparam logic CEN_ON  = 1'b0;
    localparam logic CEN_OFF = 1'b1;
    localparam logic WEN_WR  = 1'b0;
    localparam logic WEN_RD  = 1'b1;
    localparam logic OEN_ON  = 1'b0;
    localparam logic OEN_OFF = 1'b1;

    // Which channel wins the next contested cycle
    typedef enum logic [0:0] {
        PRIO_WR = 1'b0,
        PRIO_RD = 1'b1
    } prio_e;

endpackage : db_ram_1p_ctrl_pkg
`default_nettype wire

// File: rtl/db_ram_1p_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : db_ram_1p_ctrl_if
// Brief    : Request/return channels from the deblocking datapath plus the
//            active-low single-port RAM pins. The controller uses the slave
//            modport; the datapath/RAM side uses master.
// Revision : 1.0 - initial release
// ============================================================================
interface db_ram_1p_ctrl_if
    import db_ram_1p_ctrl_pkg::*;
#(
    parameter int Word_Width = DB_WORD_WIDTH,
    parameter int Addr_Width = DB_ADDR_WIDTH
);
    // Write request channel
    logic                  wr_req_i;
    logic [Addr_Width-1:0] wr_addr_i;
    logic [Word_Width-1:0] wr_data_i;
    logic                  wr_ack_o;
    // Read request channel
    logic                  rd_req_i;
    logic [Addr_Width-1:0] rd_addr_i;
    logic                  rd_ack_o;
    // Read return stream
    logic                  rd_valid_o;
    logic [Word_Width-1:0] rd_data_o;
    logic                  rd_ready_i;
    // RAM pins
    logic                  ram_cen_o;
    logic                  ram_oen_o;
    logic                  ram_wen_o;
    logic [Addr_Width-1:0] ram_addr_o;
    logic [Word_Width-1:0] ram_data_o;
    logic [Word_Width-1:0] ram_data_i;

    modport slave (
        input  wr_req_i, wr_addr_i, wr_data_i, rd_req_i, rd_addr_i,
               rd_ready_i, ram_data_i,
        output wr_ack_o, rd_ack_o, rd_valid_o, rd_data_o,
               ram_cen_o, ram_oen_o, ram_wen_o, ram_addr_o, ram_data_o
    );

    modport master (
        output wr_req_i, wr_addr_i, wr_data_i, rd_req_i, rd_addr_i,
               rd_ready_i, ram_data_i,
        input  wr_ack_o, rd_ack_o, rd_valid_o, rd_data_o,
               ram_cen_o, ram_oen_o, ram_wen_o, ram_addr_o, ram_data_o
    );

endinterface : db_ram_1p_ctrl_if
`default_nettype wire

// File: rtl/db_ram_1p_ctrl_rbuf.sv
`default_nettype none
// ============================================================================
// Module   : db_ram_1p_ctrl_rbuf
// Brief    : Circular read-return FIFO. Head data reads as zero when empty.
//            Pointers wrap modulo DEPTH, so DEPTH need not be a power of two.
// Revision : 1.0 - initial release
// ============================================================================
module db_ram_1p_ctrl_rbuf #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 2
) (
    input  wire logic                       clk,
    input  wire logic                       rst,
    input  wire logic                       i_push,
    input  wire logic [WIDTH-1:0]           i_push_data,
    input  wire logic                       i_pop,
    output logic [$clog2(DEPTH+1)-1:0]      o_count,
    output logic                            o_valid,
    output logic [WIDTH-1:0]                o_head
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [PW-1:0] c_LAST = PW'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_pop;

    // A pop on an empty buffer is ignored
    assign w_pop = i_pop & o_valid;

    // Pointer and occupancy tracking; simultaneous push/pop keeps count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push)
                r_wr_ptr <= (r_wr_ptr == c_LAST) ? '0 : r_wr_ptr + PW'(1);
            if (w_pop)
                r_rd_ptr <= (r_rd_ptr == c_LAST) ? '0 : r_rd_ptr + PW'(1);
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Data storage; contents need no reset since the head is masked when empty
    always_ff @(posedge clk) begin
        if (i_push)
            r_mem[r_wr_ptr] <= i_push_data;
    end

    assign o_count = r_count;
    assign o_valid = (r_count != '0);
    assign o_head  = o_valid ? r_mem[r_rd_ptr] : '0;

    // The upstream credit check must never let a push land in a full buffer
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(i_push && !w_pop && (r_count == CW'(DEPTH))));

endmodule : db_ram_1p_ctrl_rbuf
`default_nettype wire

// File: rtl/db_ram_1p_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : db_ram_1p_ctrl
// Brief    : Single-port deblocking RAM initiator. Arbitrates a write and a
//            read request channel onto one active-low RAM port, tracks the
//            one-cycle read latency and buffers returned data in a FIFO.
//            A read is only issued when the FIFO is guaranteed a free slot.
// Options  : DB_RAM_1P_CTRL_RR_ARB_EN - alternate priority on contested
//            cycles instead of fixed write priority.
// Revision : 1.0 - initial release
// ============================================================================
module db_ram_1p_ctrl
    import db_ram_1p_ctrl_pkg::*;
#(
    parameter int Word_Width = DB_WORD_WIDTH,
    parameter int Addr_Width = DB_ADDR_WIDTH,
    parameter int FIFO_DEPTH = 2
) (
    input  wire logic          clk,
    input  wire logic          rst,
    db_ram_1p_ctrl_if.slave    bus
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int SW = CW + 1;

    logic                  r_inflight;
    logic [Addr_Width-1:0] r_addr;
    logic [Word_Width-1:0] r_data;

    logic [CW-1:0]         w_count;
    logic                  w_valid;
    logic [Word_Width-1:0] w_head;
    logic [SW-1:0]         w_credit;
    logic                  w_pop;
    logic                  w_rd_ok;
    logic                  w_wr_elig;
    logic                  w_rd_elig;
    logic                  w_wr_gnt;
    logic                  w_rd_gnt;

    // Slots committed once this cycle's pop is accounted for
    assign w_pop     = w_valid & bus.rd_ready_i;
    assign w_credit  = SW'(w_count) + SW'(r_inflight) - SW'(w_pop);
    assign w_rd_ok   = (w_credit < SW'(FIFO_DEPTH));
    // Grants are suppressed while reset is held so the RAM stays deselected
    assign w_wr_elig = bus.wr_req_i & ~rst;
    assign w_rd_elig = bus.rd_req_i & w_rd_ok & ~rst;

`ifdef DB_RAM_1P_CTRL_RR_ARB_EN
    prio_e r_prio;
    prio_e w_prio_nxt;

    // Round-robin grant: on a contested cycle the winner yields next time
    always_comb begin
        w_wr_gnt   = w_wr_elig;
        w_rd_gnt   = w_rd_elig & ~w_wr_elig;
        w_prio_nxt = r_prio;
        if (w_wr_elig && w_rd_elig) begin
            if (r_prio == PRIO_RD) begin
                w_wr_gnt   = 1'b0;
                w_rd_gnt   = 1'b1;
                w_prio_nxt = PRIO_WR;
            end else begin
                w_prio_nxt = PRIO_RD;
            end
        end
    end

    // Priority token register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_prio <= PRIO_WR;
        else
            r_prio <= w_prio_nxt;
    end
`else
    // Fixed grant: write always beats an eligible read
    always_comb begin
        w_wr_gnt = w_wr_elig;
        w_rd_gnt = w_rd_elig & ~w_wr_elig;
    end
`endif

    // RAM pin drive; address/data hold their last value when idle
    assign bus.wr_ack_o   = w_wr_gnt;
    assign bus.rd_ack_o   = w_rd_gnt;
    assign bus.ram_cen_o  = (w_wr_gnt | w_rd_gnt) ? CEN_ON : CEN_OFF;
    assign bus.ram_wen_o  = w_wr_gnt ? WEN_WR : WEN_RD;
    assign bus.ram_oen_o  = r_inflight ? OEN_ON : OEN_OFF;
    assign bus.ram_addr_o = w_wr_gnt ? bus.wr_addr_i :
                            w_rd_gnt ? bus.rd_addr_i : r_addr;
    assign bus.ram_data_o = w_wr_gnt ? bus.wr_data_i : r_data;

    // Read-in-flight flag and held RAM address/data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inflight <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
        end else begin
            r_inflight <= w_rd_gnt;
            if (w_wr_gnt)
                r_addr <= bus.wr_addr_i;
            else if (w_rd_gnt)
                r_addr <= bus.rd_addr_i;
            if (w_wr_gnt)
                r_data <= bus.wr_data_i;
        end
    end

    db_ram_1p_ctrl_rbuf #(
        .WIDTH (Word_Width),
        .DEPTH (FIFO_DEPTH)
    ) u_rbuf (
        .clk         (clk),
        .rst         (rst),
        .i_push      (r_inflight),
        .i_push_data (bus.ram_data_i),
        .i_pop       (w_pop),
        .o_count     (w_count),
        .o_valid     (w_valid),
        .o_head      (w_head)
    );

    assign bus.rd_valid_o = w_valid;
    assign bus.rd_data_o  = w_head;

endmodule : db_ram_1p_ctrl
`default_nettype wire

// File: doc/db_ram_1p_ctrl.md
Name: db_ram_1p_ctrl

Overview:
Initiator for the active-low single-port deblocking RAM (cen/oen/wen, registered read data one cycle after a read strobe). Merges a write request channel and a read request channel onto the one RAM port. Buffers returned read data in a small FIFO with a valid/ready output. Sits between the deblocking filter datapath and its line/pixel RAM instances.

Parameters:
Word_Width, 128, RAM word width in bits
Addr_Width, 8, RAM address width in bits
FIFO_DEPTH, 2, read-return buffer entries (>=2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
wr_req_i  in  1  write request; held with addr/data until wr_ack_o
wr_addr_i  in  Addr_Width  write address
wr_data_i  in  Word_Width  write data
wr_ack_o  out  1  write accepted this cycle (combinational)
rd_req_i  in  1  read request; held with addr until rd_ack_o
rd_addr_i  in  Addr_Width  read address
rd_ack_o  out  1  read issued this cycle (combinational)
rd_valid_o  out  1  read-return FIFO head valid
rd_data_o  out  Word_Width  FIFO head data
rd_ready_i  in  1  consumer pops head when rd_valid_o & rd_ready_i
ram_cen_o  out  1  RAM chip enable, low active
ram_oen_o  out  1  RAM output enable, low active
ram_wen_o  out  1  RAM write enable, low active
ram_addr_o  out  Addr_Width  RAM address
ram_data_o  out  Word_Width  RAM write data
ram_data_i  in  Word_Width  RAM read data (z when oen high)

Behaviour:
- Reset (async, rst=1): FIFO empty, inflight=0, prio=write; rd_valid_o=0, rd_data_o=0, wr_ack_o=0, rd_ack_o=0, ram_cen_o=1, ram_wen_o=1, ram_oen_o=1, ram_addr_o=0, ram_data_o=0. Reset mid-operation discards the in-flight read and all buffered data.
- rd_ok = (count + inflight - pop) < FIFO_DEPTH, where pop = rd_valid_o & rd_ready_i.
- Grant, one access per cycle: only wr_req_i -> write; only rd_req_i & rd_ok -> read; both with rd_ok -> fixed priority, write wins; rd_req_i & !rd_ok -> no read, and a write proceeds if requested.
- Write grant: wr_ack_o=1, ram_cen_o=0, ram_wen_o=0, ram_addr_o=wr_addr_i, ram_data_o=wr_data_i.
- Read grant: rd_ack_o=1, ram_cen_o=0, ram_wen_o=1, ram_addr_o=rd_addr_i; inflight<=1 next cycle.
- Idle: ram_cen_o=1, ram_wen_o=1, ram_addr_o/ram_data_o hold their last value.
- Read return: in the cycle after a read grant (inflight=1), ram_oen_o=0 and ram_data_i is pushed into the FIFO at that clock edge. ram_oen_o=1 in all other cycles.
- Read latency: ack in cycle N -> rd_valid_o=1 in cycle N+2 at the earliest.
- Sustained reads at one per cycle with rd_ready_i=1.
- FIFO: circular, pointers wrap modulo FIFO_DEPTH. A push and pop in the same cycle leaves count unchanged. Overflow cannot occur by construction; assert on it.
- Ordering: read data returns in issue order. A write acked in cycle N is visible to a read acked in cycle N+1 or later. Same-cycle RAW is impossible because the port is single.

Optional Feature:
- Macro: DB_RAM_1P_CTRL_RR_ARB_EN.
- Defined: on each cycle where both channels are eligible, the granted channel loses priority to the other for the next conflict. prio resets to write. Uncontested grants do not change prio.
- Undefined: fixed write priority as above. A read starves while wr_req_i stays continuously high.

Decomposition:
- Shared defines/package: RAM control encodings (CEN_ON=0, WEN_WR=0, WEN_RD=1, OEN_ON=0) and default Word_Width/Addr_Width for the deblocking RAMs.
- One sub-module: db_ram_1p_ctrl_rbuf. Parameterised read-return FIFO exposing push, pop, count, valid, head data.
- Arbiter and credit logic stay in the top module.

Test Plan:
- Reset: assert rst mid-stream with FIFO holding 2 entries -> outputs at reset values immediately, rd_valid_o=0 after release, no stale data.
- Write then read: write addr 0x05 data 0xA5A5.. cycle 0; read addr 0x05 cycle 1 -> rd_ack_o cycle 1, ram_oen_o=0 cycle 2, rd_valid_o=1 and rd_data_o=0xA5A5.. cycle 3.
- Streaming: preload addrs 0..15 with value=addr; hold rd_req_i with rd_ready_i=1, addr incrementing -> 16 acks in 16 consecutive cycles, data 0..15 in order with no gaps.
- Backpressure: rd_ready_i=0 while issuing reads -> exactly FIFO_DEPTH reads acked, rd_ack_o then stays 0. Raise rd_ready_i -> data returned in order, none lost or duplicated.
- Conflict: both requests held 4 cycles, FIFO empty, ready=1 -> without macro: 4 write acks then read acks; with DB_RAM_1P_CTRL_RR_ARB_EN: acks alternate W,R,W,R.
- Read blocked by credit with write pending: FIFO full, both requests held -> write acked, read not acked until a pop.
